// File: rtl/vm_pkg.sv
// Shared definitions for the vector machine execute stage: widths, op_type
// encodings, funct codes and the execute FSM state type.
package vm_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 16;
    localparam int MUL_CYCLES = 32;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ARITH = 2'b01;
    localparam logic [1:0] OP_LOGIC = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_MUL = 4'd2;
    localparam logic [3:0] F_SLT = 4'd3;

    localparam logic [3:0] F_AND = 4'd0;
    localparam logic [3:0] F_OR  = 4'd1;
    localparam logic [3:0] F_XOR = 4'd2;
    localparam logic [3:0] F_SLL = 4'd3;
    localparam logic [3:0] F_SRL = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    function automatic logic funct_legal(input logic [1:0] op, input logic [3:0] f);
        logic ok;
        ok = 1'b0;
        if (op == OP_ARITH) ok = (f <= F_SLT);
        if (op == OP_LOGIC) ok = (f <= F_SRL);
        return ok;
    endfunction

endpackage

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier: the first partial product is taken on the
// start edge, the remaining XLEN-1 on the following edges.
module iter_mul
    import vm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [XLEN-1:0]  acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc_q    <= b[0] ? a : '0;
                mcand_q  <= a << 1;
                mplier_q <= b >> 1;
                cnt_q    <= CNT_W'(MUL_CYCLES - 1);
            end else if (cnt_q != '0) begin
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) done_q <= 1'b1;
            end
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: 16x32 register file, single-cycle ALU, iterative multiply,
// registered write-back and illegal-instruction reporting.
module ex_stage
    import vm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      op_type,
    input  logic [3:0]      operand_a,
    input  logic            operand_a_valid,
    input  logic [3:0]      operand_b,
    input  logic            operand_b_valid,
    input  logic [3:0]      operand_c,
    input  logic            operand_c_valid,
    input  logic [XLEN-1:0] immediate,
    output logic            ex_ready,
    output logic            delay,
    output logic            wb_valid,
    output logic [3:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            err,
    input  logic [3:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output state_t          dbg_state
);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  rf_q [NREG];
    logic [1:0]       op_q;
    logic [3:0]       funct_q;
    logic [3:0]       dst_q;
    logic [XLEN-1:0]  src1_q, src2_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wb_valid_q, err_q;
    logic [3:0]       wb_addr_q;
    logic [XLEN-1:0]  wb_data_q;

    logic [XLEN-1:0]  rd_b, rd_c, imm_sext, src2_in, alu_res, mul_product;
    logic [3:0]       funct_in;
    logic             accept, illegal_in, is_mul_in, mul_busy, mul_done;

    // Handshake: an instruction transfers on any rising edge where ex_ready
    // is high and op_type != OP_NONE; while ex_ready is low inputs are ignored.
    assign accept     = (state_q == IDLE) && (op_type != OP_NONE);
    assign funct_in   = immediate[31:28];
    assign imm_sext   = {{(XLEN-28){immediate[27]}}, immediate[27:0]};
    assign rd_b       = (operand_b_valid && operand_b != '0) ? rf_q[operand_b] : '0;
    assign rd_c       = (operand_c_valid && operand_c != '0) ? rf_q[operand_c] : '0;
    assign src2_in    = operand_c_valid ? rd_c : imm_sext;
    assign illegal_in = (op_type == OP_RSVD) || !operand_a_valid || !funct_legal(op_type, funct_in);
    assign is_mul_in  = (op_type == OP_ARITH) && (funct_in == F_MUL) && !illegal_in;

    iter_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul_in && !mul_busy),
        .a       (rd_b),
        .b       (src2_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_mul_in ? MUL : EXEC;
            EXEC:    state_d = IDLE;
            MUL:     if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        if (op_q == OP_ARITH) begin
            case (funct_q)
                F_ADD:   alu_res = src1_q + src2_q;
                F_SUB:   alu_res = src1_q - src2_q;
                F_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
                default: alu_res = '0;
            endcase
        end else begin
            case (funct_q)
                F_AND:   alu_res = src1_q & src2_q;
                F_OR:    alu_res = src1_q | src2_q;
                F_XOR:   alu_res = src1_q ^ src2_q;
                F_SLL:   alu_res = src1_q << src2_q[4:0];
                F_SRL:   alu_res = src1_q >> src2_q[4:0];
                default: alu_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            op_q       <= OP_NONE;
            funct_q    <= '0;
            dst_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            illegal_q  <= 1'b0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (accept) begin
                op_q      <= op_type;
                funct_q   <= funct_in;
                dst_q     <= operand_a;
                src1_q    <= rd_b;
                src2_q    <= src2_in;
                illegal_q <= illegal_in;
                if (is_mul_in) cnt_q <= CNT_W'(MUL_CYCLES - 1);
            end
            // R0 is never written, but the write-back pulse is still reported.
            if (state_q == EXEC) begin
                if (illegal_q) begin
                    err_q <= 1'b1;
                end else begin
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= dst_q;
                    wb_data_q  <= alu_res;
                    if (dst_q != '0) rf_q[dst_q] <= alu_res;
                end
            end
            if (state_q == MUL) begin
                if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                if (mul_done) begin
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= dst_q;
                    wb_data_q  <= mul_product;
                    if (dst_q != '0) rf_q[dst_q] <= mul_product;
                end
            end
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign delay     = (state_q == MUL);
    assign wb_valid  = wb_valid_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;
    assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
    assign dbg_state = state_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the vector machine, directly downstream of the instruction fetch stage. Consumes the decoded operand port (op_type, register indices, immediate), reads a 16×32 register file, performs arithmetic or logical operations and writes the result back. Multiplies use an iterative shift-add unit. It throttles fetch with `ex_ready` and `delay`.

## Interface
- `XLEN`, 32: datapath width.
- `NREG`, 16: register count; indices are 4 bits.
- `MUL_CYCLES`, 32: iterations of the multiply unit; must equal `XLEN`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `op_type` in 2: operation class.
  - 00 none.
  - 01 arithmetic.
  - 10 logical.
  - 11 reserved.
- `operand_a` in 4, with `operand_a_valid` in 1: destination register index.
- `operand_b` in 4, with `operand_b_valid` in 1: source 1 register index.
- `operand_c` in 4, with `operand_c_valid` in 1: source 2 register index.
- `immediate` in 32: [31:28] funct; [27:0] immediate operand, sign-extended to 32 bits.
- `ex_ready` out 1: high only in IDLE.
- `delay` out 1: high while in MUL.
- `wb_valid` out 1: one-cycle pulse on register write.
- `wb_addr` out 4: destination of the write.
- `wb_data` out 32: data written.
- `err` out 1: one-cycle pulse on an illegal instruction.
- `dbg_addr` in 4: debug register index.
- `dbg_data` out 32: combinational register read of `dbg_addr`.

## Operation
- **Accept.** An instruction is accepted on a rising edge where state = IDLE and `op_type` ≠ 00.
  - Latched at accept: funct, destination, src1 = R[b], src2.
  - src2 = R[c] when `operand_c_valid`, else the sign-extended immediate.
- **Register file.**
  - R0 reads as 0; writes to R0 are dropped, but `wb_valid` still pulses.
  - A missing source (valid = 0) reads as 0.
- **Arithmetic funct.**
  - 0 ADD, 1 SUB, 3 SLT (signed, result 0 or 1).
  - 2 MUL: low 32 bits of the unsigned product.
  - All results wrap modulo 2^32.
- **Logical funct.**
  - 0 AND, 1 OR, 2 XOR.
  - 3 SLL and 4 SRL, shift amount = src2[4:0].
- **Illegal instruction.** Any of the following pulses `err` in the EXEC cycle, performs no write and returns to IDLE:
  - `op_type` = 11;
  - undefined funct;
  - `operand_a_valid` = 0 at accept.
- **FSM.**
  - IDLE → EXEC on a non-MUL accept.
  - IDLE → MUL on a MUL accept; the iteration counter loads `MUL_CYCLES`−1.
  - EXEC → IDLE unconditionally; the write happens on this edge.
  - MUL: one shift-add per cycle. The counter decrements; on the edge where it is 0, write the product and go → IDLE.
- **Reset.**
  - state = IDLE; all registers = 0; counter = 0.
  - Outputs after reset: `ex_ready`=1, `delay`=0, `wb_valid`=0, `wb_addr`=0, `wb_data`=0, `err`=0.
  - Reset during MUL abandons the operation with no write.

## Timing
- **Accept at edge N.**
  - ALU op: state = EXEC during cycle N..N+1.
  - `wb_valid`/`err` are high in cycle N+1, registered from the EXEC decision; R[dst] is updated at edge N+1.
  - `ex_ready` returns high after edge N+1, so throughput is one ALU op per 2 cycles.
- **MUL.**
  - `delay`=1 and `ex_ready`=0 for exactly `MUL_CYCLES` cycles after the accept edge.
  - The write lands on edge N+`MUL_CYCLES`.
- **Input stability.** Inputs are ignored while `ex_ready`=0; the upstream stage holds or discards as it sees fit.
- **Back-to-back hazard.** An instruction accepted the cycle after a write reads the new value, because the write edge precedes the next accept edge. No forwarding logic is needed.
- **Debug read.** `dbg_data` reflects a write from the edge after that write.

## Structure
- **Shared package `vm_pkg`:**
  - op_type encodings OP_NONE, OP_ARITH, OP_LOGIC, OP_RSVD;
  - funct constants;
  - state enum IDLE, EXEC, MUL.
- **Sub-module `iter_mul`:**
  - inputs: start, a, b;
  - outputs: busy, done, product[31:0];
  - one 32-cycle shift-add multiply.
- **Top level:** regfile, FSM, ALU.

## Test plan
- Reset, then write R1=5 via ADDI (b=R0, c invalid, imm=5) → `wb_valid` at N+1, `wb_addr`=1, `wb_data`=5; `dbg_data`(R1)=5.
- With R1=5, R2=0xFFFFFFFF: SUB R3=R1−R2 → 6; SLT R4=(R2<R1) → 1; ADD R5=R2+R2 → 0xFFFFFFFE.
- With R6=0x0F0F0000: SLL with imm=4 → 0xF0F00000; SRL with imm=36 (uses 4) → 0x00F0F000; XOR with itself → 0.
- MUL R7=0x10000×0x10001 → `delay` high exactly 32 cycles, `ex_ready` low; `wb_data`=0x00010000 at edge N+32.
- `op_type`=11, funct 7 logical, and `operand_a_valid`=0 → each pulses `err` once, with no `wb_valid` and no register change; a write to R0 leaves R0=0.
- Assert `rst` at MUL cycle 10 → immediately `ex_ready`=1, `delay`=0; all registers 0; no `wb_valid` afterwards.
